multi_stream_prefetcher: RTL and testbench
==========================================

MULTI_STREAM_PREFETCHER -- requirements
Module: multi_stream_prefetcher

Interface
REQ-001 Parameter NUM_STREAMS, default 4, number of stride-stream table entries.
REQ-002 Parameter PBUF_DEPTH, default 4, number of prefetch-buffer line entries.
REQ-003 Parameter LINE_BITS, default 256, cache line data width.
REQ-004 Parameter CONF_THRESH, default 2, minimum confidence (2-bit saturating, max 3) required to issue a prefetch.
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 l1_mem_read / l1_mem_write  in  1  L1 request strobes, held until l1_mem_resp.
REQ-008 l1_mem_address  in  32  line-aligned address (bits [4:0] ignored).
REQ-009 l1_mem_wdata  in  LINE_BITS  write-back data.
REQ-010 l1_mem_rdata / l1_mem_resp  out  LINE_BITS / 1  read data and one-cycle completion pulse.
REQ-011 l2_mem_read / l2_mem_write / l2_mem_address / l2_mem_wdata  out  1/1/32/LINE_BITS  L2 request, held until l2_mem_resp.
REQ-012 l2_mem_rdata / l2_mem_resp  in  LINE_BITS / 1  L2 read data and completion pulse.

Function
REQ-013 FSM states: IDLE, PBUF_RESP, DEMAND, PREFETCH; each L2 transaction in flight is unique (at most one).
REQ-014 IDLE, L1 read hitting a valid pbuf entry: go to PBUF_RESP, which asserts l1_mem_resp with that entry's data for exactly one cycle, then returns to IDLE; no L2 access.
REQ-015 IDLE, L1 read miss or L1 write: go to DEMAND.
REQ-016 DEMAND: drive the L2 request with the L1 address, strobe and data; on l2_mem_resp, assert l1_mem_resp combinationally in the same cycle with l1_mem_rdata = l2_mem_rdata, then return to IDLE.
REQ-017 IDLE with no L1 request and pf_pending set: go to PREFETCH.
REQ-018 PREFETCH: drive l2_mem_read with pf_addr; on l2_mem_resp, fill the pbuf, clear pf_pending and return to IDLE.
REQ-019 Pbuf fill takes the lowest-index invalid entry; if none is invalid, it takes the round-robin victim pointer, which then advances modulo PBUF_DEPTH.
REQ-020 A demand request presented while PREFETCH is active waits until that prefetch completes; L2 transactions are never aborted.
REQ-021 Training: each L1 read (pbuf hit or completed demand read) trains the stream table once; writes never train.
REQ-022 Stream match compares address bits [31:12] (page) with the entry tag; new_stride = A - last_addr (32-bit wrap).
REQ-023 On match: if new_stride equals the stored stride, conf saturating-increments; otherwise stride = new_stride and conf = 0; last_addr = A in both cases.
REQ-024 On no match: allocate the round-robin stream victim with tag = page, last_addr = A, stride = 0, conf = 0.
REQ-025 After training, if conf >= CONF_THRESH and stride != 0, candidate P = A + stride.
REQ-026 P is dropped if its page differs from A's page, if P is already in the pbuf, or if P equals A.
REQ-027 Otherwise P loads pf_addr and sets pf_pending, overwriting any older pending candidate.
REQ-028 An L1 write invalidates any pbuf entry with a matching address in the cycle it leaves IDLE, and clears pf_pending if pf_addr matches.
REQ-029 A demand read to pf_addr clears pf_pending.
REQ-030 A pbuf hit invalidates the hit entry.

Reset
REQ-031 rst: state IDLE; all stream and pbuf valid bits, pf_pending, victim pointers and statistics counters are cleared; all outputs are 0.
REQ-032 Reset mid-transaction abandons the transaction; an l2_mem_resp arriving after reset in IDLE is ignored.

Configuration
REQ-033 With PF_STATS_EN defined: 32-bit outputs pf_issued (prefetches completed) and pf_useful (pbuf hits) are present, wrap on overflow, and are cleared by rst.
REQ-034 Without PF_STATS_EN: those ports and counters do not exist, and all other behaviour is unchanged.

Structure
REQ-035 Package prefetch_pkg holds the state enum, stream_entry_t {valid, tag, last_addr, stride, conf}, pbuf_entry_t {valid, addr, data}, and the constants LINE_OFFSET = 5 and PAGE_SHIFT = 12.
REQ-036 Sub-module pf_stream_table holds the match, train, allocate and candidate logic; the top level holds the FSM and the pbuf.

Verification
REQ-037 Reads 0x1000, 0x1020, 0x1040, 0x1060 (all misses) -> after 0x1060 a PREFETCH of 0x1080 is issued; a subsequent read of 0x1080 responds one cycle after the request with no L2 access.
REQ-038 Reads 0x1F80, 0x1FA0, 0x1FC0, 0x1FE0 -> candidate 0x2000 crosses the page and no prefetch is issued.
REQ-039 0x1080 in the pbuf, then a write to 0x1080 -> the write goes to L2 and a following read of 0x1080 goes to L2 (DEMAND).
REQ-040 A read of 0x3000 arrives while PREFETCH is waiting on l2_mem_resp -> the prefetch completes first, then DEMAND for 0x3000 is served; L2 sees no overlapping requests.
REQ-041 Interleaved strides +0x40 in page 0x5 and -0x20 in page 0x9, four reads each -> both streams prefetch (0x5100 and 0x9F60 for starts 0x5000 and 0x9FE0).
REQ-042 rst asserted during DEMAND -> the next cycle is IDLE, outputs are 0, and a late l2_mem_resp produces no l1_mem_resp.

Source files
------------

// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared types and constants for the multi-stream prefetcher.
// Line granularity is 32 bytes (LINE_OFFSET) and streams are tracked per
// 4 KiB page (PAGE_SHIFT). Prefetch-buffer lines hold up to PBUF_LINE_MAX bits.
package prefetch_pkg;
   localparam int LINE_OFFSET   = 5;
   localparam int PAGE_SHIFT    = 12;
   localparam int PBUF_LINE_MAX = 256;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PBUF_RESP = 2'd1,
      DEMAND    = 2'd2,
      PREFETCH  = 2'd3
   } state_t;

   typedef struct packed {
      logic                    valid;
      logic [31:PAGE_SHIFT]    tag;
      logic [31:0]             last_addr;
      logic [31:0]             stride;
      logic [1:0]              conf;
   } stream_entry_t;

   typedef struct packed {
      logic                     valid;
      logic [31:0]              addr;
      logic [PBUF_LINE_MAX-1:0] data;
   } pbuf_entry_t;

   // Drop the byte-within-line bits so all address compares are per line
   function automatic logic [31:0] line_addr(input logic [31:0] a);
      return {a[31:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
   endfunction
endpackage

// File: rtl/pf_stream_table.sv
// pf_stream_table: per-page stride detector. One training event per L1 read
// updates (or allocates) an entry and, when the stride is confident, offers a
// same-page prefetch candidate combinationally in the same cycle.
module pf_stream_table
   import prefetch_pkg::*;
#(
   parameter int NUM_STREAMS = 4,
   parameter int CONF_THRESH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        train_valid,
   input  logic [31:0] train_addr,
   output logic        cand_valid,
   output logic [31:0] cand_addr
);
   localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   stream_entry_t        tbl [NUM_STREAMS];
   logic [SW-1:0]        victim;
   logic                 hit;
   logic [SW-1:0]        hit_idx;
   logic [31:0]          a;
   logic [31:PAGE_SHIFT] page;
   logic [31:0]          new_stride;
   logic [31:0]          upd_stride;
   logic [1:0]           upd_conf;

   assign a    = line_addr(train_addr);
   assign page = a[31:PAGE_SHIFT];

   // Lowest-index valid entry tracking this page (pages are unique per table)
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
         if (tbl[i].valid && tbl[i].tag == page) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   // Stride/confidence the matched entry would take after this access
   always_comb begin
      new_stride = a - tbl[hit_idx].last_addr;
      if (new_stride == tbl[hit_idx].stride) begin
         upd_stride = tbl[hit_idx].stride;
         upd_conf   = (tbl[hit_idx].conf == 2'd3) ? 2'd3 : tbl[hit_idx].conf + 2'd1;
      end else begin
         upd_stride = new_stride;
         upd_conf   = 2'd0;
      end
   end

   // Candidate stays inside the trained page and never re-fetches the access itself
   always_comb begin
      cand_addr  = a + upd_stride;
      cand_valid = train_valid && hit && (int'(upd_conf) >= CONF_THRESH) &&
                   (upd_stride != 32'd0) && (cand_addr[31:PAGE_SHIFT] == page) &&
                   (cand_addr != a);
   end

   // Train the matched entry, or replace the round-robin victim on a new page
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_STREAMS; i++) tbl[i].valid <= 1'b0;
         victim <= '0;
      end else if (train_valid) begin
         if (hit) begin
            tbl[hit_idx].last_addr <= a;
            tbl[hit_idx].stride    <= upd_stride;
            tbl[hit_idx].conf      <= upd_conf;
         end else begin
            tbl[victim].valid     <= 1'b1;
            tbl[victim].tag       <= page;
            tbl[victim].last_addr <= a;
            tbl[victim].stride    <= 32'd0;
            tbl[victim].conf      <= 2'd0;
            victim <= (victim == SW'(NUM_STREAMS - 1)) ? '0 : victim + SW'(1);
         end
      end
   end
endmodule

// File: rtl/multi_stream_prefetcher.sv
// multi_stream_prefetcher: sits between L1 and L2, serving L1 reads from a
// small prefetch buffer when possible and otherwise forwarding them to L2.
// One L2 transaction at a time; idle L2 slots are used for stride prefetches.
// Optional build macro PF_STATS_EN adds pf_issued / pf_useful counters.
// LINE_BITS must not exceed PBUF_LINE_MAX.
module multi_stream_prefetcher
   import prefetch_pkg::*;
#(
   parameter int NUM_STREAMS = 4,
   parameter int PBUF_DEPTH  = 4,
   parameter int LINE_BITS   = 256,
   parameter int CONF_THRESH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 l1_mem_read,
   input  logic                 l1_mem_write,
   input  logic [31:0]          l1_mem_address,
   input  logic [LINE_BITS-1:0] l1_mem_wdata,
   output logic [LINE_BITS-1:0] l1_mem_rdata,
   output logic                 l1_mem_resp,
   output logic                 l2_mem_read,
   output logic                 l2_mem_write,
   output logic [31:0]          l2_mem_address,
   output logic [LINE_BITS-1:0] l2_mem_wdata,
   input  logic [LINE_BITS-1:0] l2_mem_rdata,
   input  logic                 l2_mem_resp
`ifdef PF_STATS_EN
   ,
   output logic [31:0]          pf_issued,
   output logic [31:0]          pf_useful
`endif
);
   localparam int PW = (PBUF_DEPTH > 1) ? $clog2(PBUF_DEPTH) : 1;

   state_t               state, state_nx;
   pbuf_entry_t          pbuf [PBUF_DEPTH];
   logic [PW-1:0]        pb_victim;
   logic                 pf_pending;
   logic [31:0]          pf_addr;
   logic [LINE_BITS-1:0] hit_data;

   logic [31:0]   l1_line;
   logic          l1_rd_only;
   logic          pb_hit, pb_free, cand_in_pbuf;
   logic [PW-1:0] pb_hit_idx, pb_free_idx, fill_idx;
   logic          train_valid, cand_valid;
   logic [31:0]   cand_addr;

   assign l1_line    = line_addr(l1_mem_address);
   assign l1_rd_only = l1_mem_read && !l1_mem_write;

   // Pbuf lookup for the L1 address, lowest free slot, and candidate presence
   always_comb begin
      pb_hit       = 1'b0;
      pb_hit_idx   = '0;
      pb_free      = 1'b0;
      pb_free_idx  = '0;
      cand_in_pbuf = 1'b0;
      for (int i = PBUF_DEPTH - 1; i >= 0; i--) begin
         if (pbuf[i].valid && pbuf[i].addr == l1_line) begin
            pb_hit     = 1'b1;
            pb_hit_idx = PW'(i);
         end
         if (!pbuf[i].valid) begin
            pb_free     = 1'b1;
            pb_free_idx = PW'(i);
         end
         if (pbuf[i].valid && pbuf[i].addr == cand_addr) cand_in_pbuf = 1'b1;
      end
   end

   assign fill_idx = pb_free ? pb_free_idx : pb_victim;

   // Train once per L1 read: on the pbuf hit, or when the demand read completes
   assign train_valid = (state == IDLE   && l1_rd_only && pb_hit) ||
                        (state == DEMAND && l1_rd_only && l2_mem_resp);

   pf_stream_table #(
      .NUM_STREAMS (NUM_STREAMS),
      .CONF_THRESH (CONF_THRESH)
   ) u_streams (
      .clk         (clk),
      .rst         (rst),
      .train_valid (train_valid),
      .train_addr  (l1_mem_address),
      .cand_valid  (cand_valid),
      .cand_addr   (cand_addr)
   );

   // Next state: L1 requests beat prefetches; L2 transactions run to completion
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (l1_rd_only && pb_hit)                state_nx = PBUF_RESP;
            else if (l1_mem_read || l1_mem_write)    state_nx = DEMAND;
            else if (pf_pending)                     state_nx = PREFETCH;
         end
         PBUF_RESP: state_nx = IDLE;
         DEMAND:    if (l2_mem_resp) state_nx = IDLE;
         PREFETCH:  if (l2_mem_resp) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Output decode; IDLE drives everything to zero
   always_comb begin
      l1_mem_resp    = 1'b0;
      l1_mem_rdata   = '0;
      l2_mem_read    = 1'b0;
      l2_mem_write   = 1'b0;
      l2_mem_address = 32'd0;
      l2_mem_wdata   = '0;
      case (state)
         PBUF_RESP: begin
            l1_mem_resp  = 1'b1;
            l1_mem_rdata = hit_data;
         end
         DEMAND: begin
            l2_mem_read    = l1_mem_read;
            l2_mem_write   = l1_mem_write;
            l2_mem_address = l1_line;
            l2_mem_wdata   = l1_mem_write ? l1_mem_wdata : '0;
            l1_mem_resp    = l2_mem_resp;
            l1_mem_rdata   = l2_mem_resp ? l2_mem_rdata : '0;
         end
         PREFETCH: begin
            l2_mem_read    = 1'b1;
            l2_mem_address = pf_addr;
         end
         default: ;
      endcase
   end

   // FSM state, pbuf contents and pending-prefetch bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pf_pending <= 1'b0;
         pf_addr    <= 32'd0;
         pb_victim  <= '0;
         hit_data   <= '0;
         for (int i = 0; i < PBUF_DEPTH; i++) pbuf[i].valid <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (l1_rd_only && pb_hit) begin
                  hit_data                <= pbuf[pb_hit_idx].data[LINE_BITS-1:0];
                  pbuf[pb_hit_idx].valid  <= 1'b0;
               end else if (l1_mem_write) begin
                  for (int i = 0; i < PBUF_DEPTH; i++)
                     if (pbuf[i].addr == l1_line) pbuf[i].valid <= 1'b0;
                  if (pf_addr == l1_line) pf_pending <= 1'b0;
               end else if (l1_mem_read && pf_addr == l1_line) begin
                  pf_pending <= 1'b0;
               end
            end
            PREFETCH: begin
               if (l2_mem_resp) begin
                  pbuf[fill_idx].valid                <= 1'b1;
                  pbuf[fill_idx].addr                 <= pf_addr;
                  pbuf[fill_idx].data[LINE_BITS-1:0]  <= l2_mem_rdata;
                  pf_pending                          <= 1'b0;
                  if (!pb_free)
                     pb_victim <= (pb_victim == PW'(PBUF_DEPTH - 1)) ? '0 : pb_victim + PW'(1);
               end
            end
            default: ;
         endcase
         // A fresh candidate replaces whatever was pending
         if (cand_valid && !cand_in_pbuf) begin
            pf_addr    <= cand_addr;
            pf_pending <= 1'b1;
         end
      end
   end

`ifdef PF_STATS_EN
   // Completed prefetches and pbuf hits, free-running with wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_issued <= 32'd0;
         pf_useful <= 32'd0;
      end else begin
         if (state == PREFETCH && l2_mem_resp)      pf_issued <= pf_issued + 32'd1;
         if (state == IDLE && l1_rd_only && pb_hit) pf_useful <= pf_useful + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_multi_stream_prefetcher.sv
// Directed bench for multi_stream_prefetcher: an L2 model with fixed latency
// logs every completed L2 transaction; each scenario task checks inline.
module tb_multi_stream_prefetcher;
   localparam int LB     = 256;
   localparam int L2_LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          l1_mem_read = 1'b0, l1_mem_write = 1'b0;
   logic [31:0]   l1_mem_address = '0;
   logic [LB-1:0] l1_mem_wdata = '0;
   logic [LB-1:0] l1_mem_rdata;
   logic          l1_mem_resp;
   logic          l2_mem_read, l2_mem_write;
   logic [31:0]   l2_mem_address;
   logic [LB-1:0] l2_mem_wdata;
   logic [LB-1:0] l2_mem_rdata;
   logic          l2_mem_resp;
`ifdef PF_STATS_EN
   logic [31:0]   pf_issued, pf_useful;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0]   log_addr [$];
   bit            log_wr   [$];
   logic [LB-1:0] log_wdata[$];
   int            ovl_err = 0;
   int            l2_busy = 0;
   logic [31:0]   cur_addr = '0;
   bit            stall = 1'b0;
   bit            inject = 1'b0;

   multi_stream_prefetcher dut (
      .clk            (clk),
      .rst            (rst),
      .l1_mem_read    (l1_mem_read),
      .l1_mem_write   (l1_mem_write),
      .l1_mem_address (l1_mem_address),
      .l1_mem_wdata   (l1_mem_wdata),
      .l1_mem_rdata   (l1_mem_rdata),
      .l1_mem_resp    (l1_mem_resp),
      .l2_mem_read    (l2_mem_read),
      .l2_mem_write   (l2_mem_write),
      .l2_mem_address (l2_mem_address),
      .l2_mem_wdata   (l2_mem_wdata),
      .l2_mem_rdata   (l2_mem_rdata),
      .l2_mem_resp    (l2_mem_resp)
`ifdef PF_STATS_EN
      ,
      .pf_issued      (pf_issued),
      .pf_useful      (pf_useful)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [LB-1:0] line_of(input logic [31:0] a);
      return {8{a ^ 32'h5A00_0000}};
   endfunction

   // L2 model: respond L2_LAT cycles after a request appears, log it, flag overlap
   initial begin
      l2_mem_resp  = 1'b0;
      l2_mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (l2_mem_resp) begin
            l2_mem_resp  = 1'b0;
            l2_mem_rdata = '0;
            l2_busy      = 0;
         end else if (inject) begin
            inject       = 1'b0;
            l2_mem_resp  = 1'b1;
            l2_mem_rdata = line_of(32'hDEAD_0000);
         end else if (l2_mem_read || l2_mem_write) begin
            if (l2_busy == 0) cur_addr = l2_mem_address;
            else if (l2_mem_address != cur_addr) ovl_err++;
            if (l2_mem_read && l2_mem_write) ovl_err++;
            l2_busy++;
            if (!stall && l2_busy >= L2_LAT) begin
               log_addr.push_back(l2_mem_address);
               log_wr.push_back(l2_mem_write);
               log_wdata.push_back(l2_mem_wdata);
               l2_mem_resp  = 1'b1;
               l2_mem_rdata = line_of(l2_mem_address);
            end
         end else begin
            l2_busy = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      l1_mem_read = 1'b0; l1_mem_write = 1'b0; l1_mem_address = '0; l1_mem_wdata = '0;
      tick(); tick();
      rst = 1'b0;
      log_addr.delete(); log_wr.delete(); log_wdata.delete();
      ovl_err = 0;
   endtask

   // One L1 access held until resp; lat counts negedges up to and including resp
   task automatic l1_access(input bit wr, input logic [31:0] addr, input logic [LB-1:0] wd,
                            output logic [LB-1:0] rd, output int lat);
      bit got;
      l1_mem_read = !wr; l1_mem_write = wr; l1_mem_address = addr; l1_mem_wdata = wr ? wd : '0;
      rd = '0; lat = 0; got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (l1_mem_resp) begin rd = l1_mem_rdata; got = 1'b1; end
      end
      if (!got) begin
         errors++; checks++;
         $display("FAIL timeout_%h: no l1_mem_resp within 50 cycles", addr);
         lat = -1;
      end
      tick();
      l1_mem_read = 1'b0; l1_mem_write = 1'b0; l1_mem_wdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({l1_mem_resp, l2_mem_read, l2_mem_write} !== 3'b000) begin
         errors++; $display("FAIL reset_strobes: got %b expected 000", {l1_mem_resp, l2_mem_read, l2_mem_write});
      end
      checks++;
      if (l2_mem_address !== 32'd0 || l2_mem_wdata !== '0 || l1_mem_rdata !== '0) begin
         errors++; $display("FAIL reset_buses: addr=%h wdata=%h rdata=%h expected all zero", l2_mem_address, l2_mem_wdata, l1_mem_rdata);
      end
`ifdef PF_STATS_EN
      checks++;
      if (pf_issued !== 32'd0 || pf_useful !== 32'd0) begin
         errors++; $display("FAIL reset_stats: issued=%0d useful=%0d expected 0 0", pf_issued, pf_useful);
      end
`endif
      do_reset();
   endtask

   task automatic test_stride_prefetch();
      logic [LB-1:0] rd; int lat; logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = 32'h1000 + 32'(i) * 32'h20;
         l1_access(1'b0, a, '0, rd, lat);
         checks++;
         if (lat !== 3 || rd !== line_of(a)) begin
            errors++; $display("FAIL miss_%h: lat=%0d data=%h expected lat=3 data=%h", a, lat, rd, line_of(a));
         end
      end
      idle(6);
      checks++;
      if (log_addr.size() !== 5 || log_addr[4] !== 32'h1080 || log_wr[4] !== 1'b0) begin
         errors++; $display("FAIL pf_issue_1080: log size=%0d last=%h expected 5 entries ending in read 00001080", log_addr.size(), log_addr[log_addr.size()-1]);
      end
      l1_access(1'b0, 32'h1080, '0, rd, lat);
      checks++;
      if (lat !== 2 || rd !== line_of(32'h1080)) begin
         errors++; $display("FAIL pbuf_hit_1080: lat=%0d data=%h expected lat=2 data=%h", lat, rd, line_of(32'h1080));
      end
      checks++;
      if (log_addr.size() !== 5) begin
         errors++; $display("FAIL pbuf_hit_no_l2: l2 count=%0d expected 5", log_addr.size());
      end
`ifdef PF_STATS_EN
      checks++;
      if (pf_issued !== 32'd1 || pf_useful !== 32'd1) begin
         errors++; $display("FAIL stats_1080: issued=%0d useful=%0d expected 1 1", pf_issued, pf_useful);
      end
`endif
   endtask

   task automatic test_page_cross();
      logic [LB-1:0] rd; int lat; logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = 32'h1F80 + 32'(i) * 32'h20;
         l1_access(1'b0, a, '0, rd, lat);
      end
      idle(6);
      checks++;
      if (log_addr.size() !== 4 || log_addr[3] !== 32'h1FE0) begin
         errors++; $display("FAIL page_cross: l2 count=%0d expected 4 (no prefetch of 00002000)", log_addr.size());
      end
   endtask

   task automatic test_write_invalidate();
      logic [LB-1:0] rd, wd; int lat; logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = 32'h1000 + 32'(i) * 32'h20;
         l1_access(1'b0, a, '0, rd, lat);
      end
      idle(6);
      wd = {8{32'hC0DE_F00D}};
      l1_access(1'b1, 32'h1080, wd, rd, lat);
      checks++;
      if (log_addr.size() !== 6 || log_wr[5] !== 1'b1 || log_addr[5] !== 32'h1080 || log_wdata[5] !== wd) begin
         errors++; $display("FAIL write_to_l2: count=%0d last addr=%h wr=%b expected 6 entries ending in write 00001080", log_addr.size(), log_addr[log_addr.size()-1], log_wr[log_wr.size()-1]);
      end
      l1_access(1'b0, 32'h1080, '0, rd, lat);
      checks++;
      if (lat !== 3 || rd !== line_of(32'h1080) || log_addr.size() !== 7 || log_wr[6] !== 1'b0) begin
         errors++; $display("FAIL read_after_write: lat=%0d l2 count=%0d expected lat=3 count=7 (DEMAND)", lat, log_addr.size());
      end
   endtask

   task automatic test_demand_during_prefetch();
      logic [LB-1:0] rd; int lat; logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a = 32'h1000 + 32'(i) * 32'h20;
         l1_access(1'b0, a, '0, rd, lat);
      end
      tick();
      l1_access(1'b0, 32'h3000, '0, rd, lat);
      checks++;
      if (lat !== 5 || rd !== line_of(32'h3000)) begin
         errors++; $display("FAIL demand_wait: lat=%0d data=%h expected lat=5 data=%h", lat, rd, line_of(32'h3000));
      end
      checks++;
      if (log_addr.size() !== 6 || log_addr[4] !== 32'h1080 || log_addr[5] !== 32'h3000) begin
         errors++; $display("FAIL demand_order: count=%0d expected 6 with 00001080 then 00003000", log_addr.size());
      end
      checks++;
      if (ovl_err !== 0) begin
         errors++; $display("FAIL l2_overlap: got %0d overlapping requests expected 0", ovl_err);
      end
   endtask

   task automatic test_two_streams();
      logic [LB-1:0] rd; int lat;
      logic [31:0] seq [8];
      seq = '{32'h5000, 32'h9FE0, 32'h5040, 32'h9FC0, 32'h5080, 32'h9FA0, 32'h50C0, 32'h9F80};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         l1_access(1'b0, seq[i], '0, rd, lat);
         idle(6);
      end
      checks++;
      if (log_addr.size() !== 10 || log_addr[7] !== 32'h5100 || log_addr[9] !== 32'h9F60) begin
         errors++; $display("FAIL two_stream_pf: count=%0d expected 10 with prefetches 00005100 and 00009F60", log_addr.size());
      end
      l1_access(1'b0, 32'h5100, '0, rd, lat);
      checks++;
      if (lat !== 2 || rd !== line_of(32'h5100)) begin
         errors++; $display("FAIL hit_5100: lat=%0d data=%h expected lat=2 data=%h", lat, rd, line_of(32'h5100));
      end
      l1_access(1'b0, 32'h9F60, '0, rd, lat);
      checks++;
      if (lat !== 2 || rd !== line_of(32'h9F60) || log_addr.size() !== 10) begin
         errors++; $display("FAIL hit_9F60: lat=%0d l2 count=%0d expected lat=2 count=10", lat, log_addr.size());
      end
`ifdef PF_STATS_EN
      checks++;
      if (pf_issued !== 32'd2 || pf_useful !== 32'd2) begin
         errors++; $display("FAIL stats_two: issued=%0d useful=%0d expected 2 2", pf_issued, pf_useful);
      end
`endif
   endtask

   task automatic test_reset_mid_demand();
      logic [LB-1:0] rd; int lat; bit bad;
      do_reset();
      stall = 1'b1;
      l1_mem_read = 1'b1; l1_mem_address = 32'h3000;
      tick();
      @(negedge clk);
      checks++;
      if (l2_mem_read !== 1'b1 || l2_mem_address !== 32'h3000) begin
         errors++; $display("FAIL demand_start: read=%b addr=%h expected 1 00003000", l2_mem_read, l2_mem_address);
      end
      rst = 1'b1; l1_mem_read = 1'b0;
      tick();
      rst = 1'b0; inject = 1'b1;
      @(negedge clk);
      checks++;
      if ({l1_mem_resp, l2_mem_read, l2_mem_write} !== 3'b000 || l2_mem_address !== 32'd0 || l1_mem_rdata !== '0) begin
         errors++; $display("FAIL rst_mid_demand: resp=%b rd=%b wr=%b addr=%h expected all zero", l1_mem_resp, l2_mem_read, l2_mem_write, l2_mem_address);
      end
      bad = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (l1_mem_resp || l2_mem_read || l2_mem_write) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++; $display("FAIL late_l2_resp: got activity=%b expected 0", bad);
      end
      tick();
      stall = 1'b0;
      l1_access(1'b0, 32'h3040, '0, rd, lat);
      checks++;
      if (lat !== 3 || rd !== line_of(32'h3040)) begin
         errors++; $display("FAIL post_rst_read: lat=%0d data=%h expected lat=3 data=%h", lat, rd, line_of(32'h3040));
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_stride_prefetch();
      test_page_cross();
      test_write_invalidate();
      test_demand_during_prefetch();
      test_two_streams();
      test_reset_mid_demand();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
